// File: rtl/programcounter_stack.sv
// ----------------------------------------------------------------------------
// programcounter_stack
//
// Program counter for the microprocessor datapath. It supports absolute and
// PC-relative jumps, conditional jumps, and CALL/RET through a hardware
// return-address stack. It also provides a stall input, a restart address,
// stack status outputs and sticky overflow/underflow error flags.
//
// Every output is registered or derived only from registered state. No
// combinational path runs from any input to any output.
//
// Parameters
//   N          PC / address width in bits (2..32)
//   DEPTH      return-stack depth in entries (1..16)
//   RESET_ADDR PC value loaded on rst or start
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (PC, sp and error flags)
//   start       synchronous restart (PC and sp only; error flags are kept)
//   en          1 = advance this cycle, 0 = hold all state
//   addr        jump/call target, or a signed offset when REL = 1
//   JP          unconditional jump
//   JF          jump taken when Flag = 1
//   Flag        condition flag from the ALU
//   CALL        push return address (PC+1) and jump to the target
//   RET         pop return address into PC
//   REL         0 = absolute target, 1 = PC + addr (modulo 2^N)
//   PC          current program counter
//   sp          number of valid stack entries
//   stack_full  sp == DEPTH
//   stack_empty sp == 0
//   ovf_err     sticky flag: CALL attempted while the stack was full
//   udf_err     sticky flag: RET attempted while the stack was empty
// ----------------------------------------------------------------------------
module programcounter_stack #(
   parameter int             N          = 8,
   parameter int             DEPTH      = 4,
   parameter logic [N-1:0]   RESET_ADDR = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         en,
   input  logic [N-1:0]                 addr,
   input  logic                         JP,
   input  logic                         JF,
   input  logic                         Flag,
   input  logic                         CALL,
   input  logic                         RET,
   input  logic                         REL,
   output logic [N-1:0]                 PC,
   output logic [$clog2(DEPTH+1)-1:0]   sp,
   output logic                         stack_full,
   output logic                         stack_empty,
   output logic                         ovf_err,
   output logic                         udf_err
);

   localparam int SPW = $clog2(DEPTH + 1);

   // The stack is sized to the full range of sp. Any value sp can hold is
   // then a legal index, so no index needs range guarding.
   logic [N-1:0]   stack [2**SPW];

   logic [N-1:0]   pc_inc;
   logic [N-1:0]   target;
   logic [N-1:0]   pc_next;
   logic [SPW-1:0] sp_next;
   logic           ovf_next;
   logic           udf_next;
   logic           push;

   assign stack_full  = (sp == SPW'(DEPTH));
   assign stack_empty = (sp == '0);

   // Both sums wrap modulo 2^N. Adding the raw N-bit addr gives the
   // two's-complement signed offset without any sign extension.
   assign pc_inc = PC + N'(1);
   assign target = REL ? (PC + addr) : addr;

   // Next-state selection, in priority order: start > stall > RET > CALL >
   // JP > JF&Flag > increment. rst is handled in the register process.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one
      // unassigned. An unassigned path would infer a latch.
      pc_next  = PC;
      sp_next  = sp;
      ovf_next = ovf_err;
      udf_next = udf_err;
      push     = 1'b0;

      if (start) begin
         pc_next = RESET_ADDR;
         sp_next = '0;
      end else if (en) begin
         if (RET) begin
            // RET takes priority over CALL. A CALL in the same cycle is
            // dropped silently and raises no error.
            if (!stack_empty) begin
               pc_next = stack[sp - SPW'(1)];
               sp_next = sp - SPW'(1);
            end else begin
               pc_next  = pc_inc;
               udf_next = 1'b1;
            end
         end else if (CALL) begin
            if (!stack_full) begin
               push    = 1'b1;
               pc_next = target;
               sp_next = sp + SPW'(1);
            end else begin
               pc_next  = pc_inc;
               ovf_next = 1'b1;
            end
         end else if (JP || (JF && Flag)) begin
            pc_next = target;
         end else begin
            pc_next = pc_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments. All of them
      // therefore update together from the values sampled at the edge.
      if (rst) begin
         PC      <= RESET_ADDR;
         sp      <= '0;
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         PC      <= pc_next;
         sp      <= sp_next;
         ovf_err <= ovf_next;
         udf_err <= udf_next;
      end
   end

   // NOTE: the stack storage is deliberately not reset. A slot is read only
   // after a push has written it, and leaving it unreset lets it map onto
   // plain RAM/flops with no reset network.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         stack[sp] <= pc_inc;
      end
   end

endmodule

// File: doc/programcounter_stack.md
Name: programcounter_stack

Overview:
Parametrised next-generation program counter for the microprocessor datapath. It adds the following to the existing absolute/conditional jump behaviour:
- a hardware return-address stack for CALL/RET
- PC-relative jump mode
- a stall (enable) input
- a configurable restart address
- stack status and sticky error flags

It sits between the instruction decoder (control inputs) and the instruction memory address port (PC).

Parameters:
N, 8, PC/address width in bits (2..32)
DEPTH, 4, return stack depth in entries (1..16)
RESET_ADDR, 0, PC value loaded on rst or start (N bits)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  synchronous restart: PC<=RESET_ADDR, stack emptied, error flags kept
en  in  1  1=advance PC this cycle, 0=stall (hold all state)
addr  in  N  jump/call target; signed offset when REL=1
JP  in  1  unconditional jump
JF  in  1  jump if Flag=1
Flag  in  1  condition flag from ALU
CALL  in  1  push return address, jump to target
RET  in  1  pop return address into PC
REL  in  1  0=absolute target, 1=target = PC + addr (two's complement, modulo 2^N)
PC  out  N  current program counter (registered)
sp  out  $clog2(DEPTH+1)  number of valid stack entries
stack_full  out  1  sp==DEPTH
stack_empty  out  1  sp==0
ovf_err  out  1  sticky: CALL attempted while full
udf_err  out  1  sticky: RET attempted while empty

Behaviour:
- Reset (rst=1 at edge): PC=RESET_ADDR, sp=0, ovf_err=0, udf_err=0. Stack contents are don't-care. stack_empty=1, stack_full=0.
- Priority, evaluated each rising edge: rst > start > (en=0 hold) > RET > CALL > JP > (JF & Flag) > increment.
- start=1: PC=RESET_ADDR, sp=0. ovf_err/udf_err unchanged. en is ignored.
- en=0: PC, sp, stack and error flags all hold. Control inputs are ignored.
- Target T: REL=0 -> T=addr. REL=1 -> T=(PC+addr) mod 2^N, with addr interpreted as signed N-bit.
- Increment: PC<=(PC+1) mod 2^N. Wrap from 2^N-1 to 0 is silent.
- JP=1: PC<=T.
- JF=1 with Flag=1: PC<=T.
- JF=1 with Flag=0: increment.
- CALL=1, not full:
  - stack[sp]<=(PC+1) mod 2^N; sp<=sp+1; PC<=T.
  - The pushed return address is always PC+1, independent of REL.
- CALL=1, full: no push; PC increments; ovf_err<=1.
- RET=1, not empty: PC<=stack[sp-1]; sp<=sp-1.
- RET=1, empty: PC increments; udf_err<=1.
- RET and CALL both 1: RET wins. CALL is ignored and sets no error.
- Multiple jump strobes: highest priority wins. Lower strobes have no side effect.
- Latency: every change is visible on PC one cycle after the sampling edge. No combinational path exists from inputs to any output.
- Flag derivation: stack_full, stack_empty and sp are derived from the registered sp only.
- Sticky error flags: ovf_err/udf_err stay 1 until rst.
- Reset mid-operation: rst has priority over every other input in the same cycle. Stack state is fully discarded.

Test Plan:
- Reset/increment: rst 1 cycle, then en=1 with no strobes for 300 cycles (N=8). PC goes 0,1,2,...,255,0,1,...; sp=0 and stack_empty=1 throughout.
- Absolute and conditional jumps: at PC=5 apply JP,addr=0x40 -> PC=0x40. JF=1,Flag=0 -> PC=0x41. JF=1,Flag=1,addr=0x10 -> PC=0x10.
- Relative jump: PC=0x10, REL=1, JP=1, addr=0xFC (-4) -> PC=0x0C. PC=0xFE, addr=0x05 -> PC=0x03 (wrap).
- Nested call/return, DEPTH=4:
  - CALL at PC=2->0x20, at 0x20->0x30, at 0x30->0x40: sp=3.
  - Three RETs -> PC=0x31, 0x21, 0x03; sp=0, stack_empty=1.
- Overflow/underflow:
  - Five CALLs with DEPTH=4: fifth leaves sp=4, stack_full=1, PC=prev+1, ovf_err=1.
  - start, then RET -> PC=RESET_ADDR+1, udf_err=1.
  - Both flags hold until rst.
- Stall and priority:
  - en=0 with JP/CALL/RET asserted for 3 cycles -> PC and sp unchanged.
  - CALL+RET together with sp=1 -> pop only, sp=0.
  - rst asserted together with CALL -> PC=RESET_ADDR, sp=0.
